shifter_arbiter: RTL and testbench
==================================

Name: shifter_arbiter

Overview:
Shares one combinational barrelshifter32 among NUM_REQ requesters. Each requester uses a valid/ready handshake. Each cycle, a round-robin arbiter grants one pending request, drives the shifter with it, and registers the result plus requester ID into a single-entry output stage. Sits between the ALU-side command sources and the writeback path.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of resp_id; must equal clog2(NUM_REQ)
CNT_W, 16, width of the completed-operation counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester grant; one-hot or zero
req_a  in  NUM_REQ*32  operand, requester i at bits [32*i+31:32*i]
req_b  in  NUM_REQ*5  shift amount, requester i at bits [5*i+4:5*i]
req_aluc  in  NUM_REQ*2  op: 00 SRA, 01 SLA, 10 SRL, 11 SLL
resp_valid  out  1  result valid
resp_ready  in  1  downstream accepts result
resp_c  out  32  shifted result
resp_id  out  ID_W  index of the requester that issued the result
op_count  out  CNT_W  number of completed transfers (resp_valid && resp_ready)

Behaviour:
- Reset: synchronous, active-high. At the clk edge with rst=1, all state clears: resp_valid=0, resp_c=0, resp_id=0, rr_ptr=0, op_count=0. req_ready is forced to 0 while rst=1.
- Reset mid-operation: a pending result is dropped. No grant is issued in the reset cycle.
- can_accept = !resp_valid || resp_ready. This allows the output to be refilled in the same cycle it drains.
- Arbitration is combinational:
  - Scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit is the winner.
  - req_ready[winner] = can_accept. All other req_ready bits are 0.
- The transfer on requester i occurs when req_valid[i] && req_ready[i]. At that edge:
  - resp_c <= shifter(a_i, b_i, aluc_i)
  - resp_id <= i
  - resp_valid <= 1
  - rr_ptr <= (i+1) mod NUM_REQ
- Latency: exactly 1 cycle from grant edge to resp_valid.
- Throughput: 1 op/cycle when resp_ready is held at 1.
- Stall: while resp_valid && !resp_ready, resp_c and resp_id hold stable and every req_ready bit is 0.
- Drain with no new grant: resp_valid <= 0, while resp_c and resp_id hold their last values.
- No req_valid asserted: no grant is issued and rr_ptr is unchanged.
- op_count increments on each resp_valid && resp_ready and wraps from 2^CNT_W-1 to 0.
- Shift semantics:
  - SRA sign-fills.
  - SRL zero-fills.
  - SLA and SLL are identical: zero-fill left.
  - b=0 passes a unchanged.
- Requesters must hold a, b and aluc stable while valid and not yet granted. The block does not latch inputs before the grant.
- rr_ptr is ID_W bits wide. The wrap from NUM_REQ-1 to 0 is explicit, so it remains correct when NUM_REQ is not a power of two.

Decomposition:
- Shared package/header holds:
  - ALUC_SRA=2'b00, ALUC_SLA=2'b01, ALUC_SRL=2'b10, ALUC_SLL=2'b11
  - SHIFT_W=5, DATA_W=32
- Sub-module: the existing barrelshifter32, instantiated once and fed by the winner mux.
- The round-robin pick is a function or generate loop inside shifter_arbiter. It is not a separate module.

Test Plan:
- Basic op set. Hold resp_ready=1 and issue from requester 0 with a=0xD5555D55. Each op's result appears 1 cycle after its grant with resp_id=0:
  - b=6, aluc=00 -> resp_c=0xFF555575
  - b=6, aluc=10 -> 0x03555575
  - b=2, aluc=01 -> 0x55557554
  - b=4, aluc=11 -> 0x5555D550
  - b=16, aluc=11 -> 0x5D550000
- Round-robin. All 4 requesters hold valid with resp_ready=1, starting from rr_ptr=0. Grants go 0,1,2,3,0 on consecutive cycles, resp_id follows one cycle later, and op_count reaches 5.
- Backpressure. resp_ready=0 for 3 cycles with requesters 1 and 2 valid. Requester 1 is granted once; resp_c and resp_id stay frozen; req_ready=0 throughout the stall. On resp_ready=1, requester 2 is granted in that same cycle.
- Skip idle. Only requester 3 valid, with rr_ptr=1. Requester 3 is granted and rr_ptr becomes 0. The next cycle with no valid produces no grant, and resp_valid drops after the drain.
- Reset mid-operation. Assert rst for one cycle while resp_valid=1 and resp_ready=0. Next cycle: resp_valid=0, op_count=0, rr_ptr=0, no grant during rst.
- Counter wrap. With CNT_W=4, run 17 transfers -> op_count=1.

Source files
------------

// File: rtl/shifter_arbiter_pkg.sv
// Shared constants and helpers for the shifter arbiter.
// Op encodings, datapath widths and a bit-reverse helper.
package shifter_arbiter_pkg;

    localparam int DATA_W  = 32;
    localparam int SHIFT_W = 5;

    localparam logic [1:0] ALUC_SRA = 2'b00;
    localparam logic [1:0] ALUC_SLA = 2'b01;
    localparam logic [1:0] ALUC_SRL = 2'b10;
    localparam logic [1:0] ALUC_SLL = 2'b11;

    // Left shifts reuse the right-shift network on a reversed word.
    function automatic logic [DATA_W-1:0] rev_bits(
        input logic [DATA_W-1:0] v
    );
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = v[DATA_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shifter_arbiter_barrelshifter32.sv
// 32-bit combinational barrel shifter.
// Log-depth right shifter; left shifts wrap it in bit reversal.
module barrelshifter32
    import shifter_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0]  a,
    input  logic [SHIFT_W-1:0] b,
    input  logic [1:0]         aluc,
    output logic [DATA_W-1:0]  c
);

    logic              left;
    logic              fill;
    logic [DATA_W-1:0] s0;
    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s2;
    logic [DATA_W-1:0] s3;
    logic [DATA_W-1:0] s4;
    logic [DATA_W-1:0] s5;

    assign left = (aluc == ALUC_SLA) || (aluc == ALUC_SLL);
    // Only SRA replicates the sign bit; all other ops shift in zeros.
    assign fill = (aluc == ALUC_SRA) && a[DATA_W-1];

    assign s0 = left ? rev_bits(a) : a;
    assign s1 = b[0] ? {fill, s0[31:1]} : s0;
    assign s2 = b[1] ? {{2{fill}}, s1[31:2]} : s1;
    assign s3 = b[2] ? {{4{fill}}, s2[31:4]} : s2;
    assign s4 = b[3] ? {{8{fill}}, s3[31:8]} : s3;
    assign s5 = b[4] ? {{16{fill}}, s4[31:16]} : s4;

    assign c = left ? rev_bits(s5) : s5;

endmodule

// File: rtl/shifter_arbiter.sv
// Round-robin arbiter sharing one barrel shifter among requesters.
// The winner's operands feed the shifter; the result is registered.
module shifter_arbiter
    import shifter_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]  req_a,
    input  logic [NUM_REQ*SHIFT_W-1:0] req_b,
    input  logic [NUM_REQ*2-1:0]       req_aluc,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [DATA_W-1:0]          resp_c,
    output logic [ID_W-1:0]            resp_id,
    output logic [CNT_W-1:0]           op_count
);

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    win;
    logic               found;
    logic               can_accept;
    logic               grant;
    logic [DATA_W-1:0]  a_sel;
    logic [SHIFT_W-1:0] b_sel;
    logic [1:0]         aluc_sel;
    logic [DATA_W-1:0]  shift_c;
    logic [ID_W-1:0]    next_ptr;

    // The output slot may refill in the same cycle it drains.
    assign can_accept = !resp_valid || resp_ready;
    assign grant      = found && can_accept && !rst;

    // Scan from rr_ptr with explicit wrap so non-power-of-two counts work.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] idx_w;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        idx_w = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = ID_W'(idx);
            if (!found && req_valid[idx_w]) begin
                found = 1'b1;
                win   = idx_w;
            end
        end
    end

    // Route the winner's operands to the shared shifter.
    always_comb begin
        a_sel    = '0;
        b_sel    = '0;
        aluc_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win == ID_W'(k)) begin
                a_sel    = req_a[k*DATA_W +: DATA_W];
                b_sel    = req_b[k*SHIFT_W +: SHIFT_W];
                aluc_sel = req_aluc[k*2 +: 2];
            end
        end
    end

    // Grant is one-hot on the winner, or all zero when stalled/idle.
    always_comb begin
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_ready[k] = grant && (win == ID_W'(k));
        end
    end

    assign next_ptr = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);

    barrelshifter32 u_shift (
        .a    (a_sel),
        .b    (b_sel),
        .aluc (aluc_sel),
        .c    (shift_c)
    );

    // Output stage, round-robin pointer and completion counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_c     <= '0;
            resp_id    <= '0;
            rr_ptr     <= '0;
            op_count   <= '0;
        end else begin
            if (grant) begin
                resp_valid <= 1'b1;
                resp_c     <= shift_c;
                resp_id    <= win;
                rr_ptr     <= next_ptr;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
            if (resp_valid && resp_ready) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed bench for shifter_arbiter.
// Vector table for the shifter ops plus arbitration sequences.
module tb_shifter_arbiter;

    localparam int NR = 4;
    localparam int IW = 2;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [NR-1:0]  req_valid;
    logic [NR-1:0]  req_ready;
    logic [NR*32-1:0] req_a;
    logic [NR*5-1:0]  req_b;
    logic [NR*2-1:0]  req_aluc;
    logic           resp_valid;
    logic           resp_ready;
    logic [31:0]    resp_c;
    logic [IW-1:0]  resp_id;
    logic [CW-1:0]  op_count;

    always #5 clk = ~clk;

    shifter_arbiter #(
        .NUM_REQ (NR),
        .ID_W    (IW),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_aluc   (req_aluc),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_c     (resp_c),
        .resp_id    (resp_id),
        .op_count   (op_count)
    );

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [4:0]  b;
        logic [1:0]  aluc;
        logic [31:0] c;
    } vec_t;

    vec_t vt[10];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a,
                           input logic [4:0] b, input logic [1:0] op);
        req_a[i*32 +: 32] = a;
        req_b[i*5 +: 5]   = b;
        req_aluc[i*2 +: 2] = op;
    endtask

    function automatic logic [31:0] onehot(input int i);
        logic [31:0] r;
        r = 32'd1 << i;
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vt[0] = '{0, 32'hD5555D55, 5'd6,  2'b00, 32'hFF555575};
        vt[1] = '{0, 32'hD5555D55, 5'd6,  2'b10, 32'h03555575};
        vt[2] = '{0, 32'hD5555D55, 5'd2,  2'b01, 32'h55557554};
        vt[3] = '{0, 32'hD5555D55, 5'd4,  2'b11, 32'h5555D550};
        vt[4] = '{0, 32'hD5555D55, 5'd16, 2'b11, 32'h5D550000};
        vt[5] = '{1, 32'hD5555D55, 5'd0,  2'b00, 32'hD5555D55};
        vt[6] = '{2, 32'h80000000, 5'd31, 2'b00, 32'hFFFFFFFF};
        vt[7] = '{3, 32'h80000000, 5'd31, 2'b10, 32'h00000001};
        vt[8] = '{2, 32'h12345678, 5'd8,  2'b00, 32'h00123456};
        vt[9] = '{1, 32'h00000001, 5'd31, 2'b01, 32'h80000000};

        rst        = 1'b1;
        req_valid  = '1;
        resp_ready = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_aluc   = '0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_c", resp_c, 32'd0);
        chk("rst_id", 32'(resp_id), 32'd0);
        chk("rst_cnt", 32'(op_count), 32'd0);
        rst       = 1'b0;
        req_valid = '0;

        // Table of shifter ops, back to back with resp_ready high
        resp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            req_valid = '0;
            req_a     = '0;
            req_b     = '0;
            req_aluc  = '0;
            set_req(vt[k].id, vt[k].a, vt[k].b, vt[k].aluc);
            req_valid[vt[k].id] = 1'b1;
            #1;
            chk("vec_ready", 32'(req_ready), onehot(vt[k].id));
            tick();
            chk("vec_valid", 32'(resp_valid), 32'd1);
            chk("vec_c", resp_c, vt[k].c);
            chk("vec_id", 32'(resp_id), 32'(vt[k].id));
            chk("vec_cnt", 32'(op_count), 32'(k));
        end
        req_valid = '0;
        #1;
        chk("idle_ready", 32'(req_ready), 32'd0);
        tick();
        chk("drain_valid", 32'(resp_valid), 32'd0);
        chk("drain_c", resp_c, 32'h80000000);
        chk("drain_id", 32'(resp_id), 32'd1);
        chk("drain_cnt", 32'(op_count), 32'd10);

        // Round-robin with all four requesters valid
        do_reset();
        for (int i = 0; i < NR; i++) begin
            set_req(i, 32'(i + 1), 5'd0, 2'b11);
        end
        req_valid  = '1;
        resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_ready", 32'(req_ready), onehot(k % 4));
            tick();
            chk("rr_id", 32'(resp_id), 32'(k % 4));
            chk("rr_c", resp_c, 32'(k % 4 + 1));
        end
        req_valid = '0;
        tick();
        chk("rr_cnt", 32'(op_count), 32'd5);
        chk("rr_drain", 32'(resp_valid), 32'd0);

        // Backpressure: requester 1 then 2, rr_ptr is now 1
        resp_ready = 1'b0;
        set_req(1, 32'h11110000, 5'd4, 2'b10);
        set_req(2, 32'hF0000000, 5'd4, 2'b00);
        req_valid = 4'b0110;
        #1;
        chk("bp_grant1", 32'(req_ready), 32'b0010);
        tick();
        chk("bp_valid", 32'(resp_valid), 32'd1);
        chk("bp_id1", 32'(resp_id), 32'd1);
        chk("bp_c1", resp_c, 32'h01111000);
        req_valid = 4'b0100;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("bp_stall_ready", 32'(req_ready), 32'd0);
            tick();
            chk("bp_hold_c", resp_c, 32'h01111000);
            chk("bp_hold_id", 32'(resp_id), 32'd1);
            chk("bp_hold_v", 32'(resp_valid), 32'd1);
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_grant2", 32'(req_ready), 32'b0100);
        tick();
        chk("bp_id2", 32'(resp_id), 32'd2);
        chk("bp_c2", resp_c, 32'hFF000000);
        chk("bp_cnt", 32'(op_count), 32'd6);
        req_valid = '0;
        tick();
        chk("bp_drain_cnt", 32'(op_count), 32'd7);

        // Skip idle: move rr_ptr to 1, then only requester 3 valid
        set_req(0, 32'h00000001, 5'd1, 2'b11);
        req_valid = 4'b0001;
        #1;
        chk("si_pre", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        tick();
        set_req(3, 32'h0000000F, 5'd4, 2'b11);
        req_valid = 4'b1000;
        #1;
        chk("si_ready3", 32'(req_ready), 32'b1000);
        tick();
        chk("si_id3", 32'(resp_id), 32'd3);
        chk("si_c3", resp_c, 32'h000000F0);
        req_valid = '0;
        #1;
        chk("si_nogrant", 32'(req_ready), 32'd0);
        tick();
        chk("si_drop", 32'(resp_valid), 32'd0);
        chk("si_hold_id", 32'(resp_id), 32'd3);
        chk("si_cnt", 32'(op_count), 32'd9);
        set_req(0, 32'h00000005, 5'd0, 2'b11);
        req_valid = 4'b1001;
        #1;
        chk("si_wrap_ptr", 32'(req_ready), 32'b0001);
        tick();
        chk("si_id0", 32'(resp_id), 32'd0);
        chk("si_v0", 32'(resp_valid), 32'd1);

        // Reset while a result is stalled
        resp_ready = 1'b0;
        req_valid  = '1;
        rst        = 1'b1;
        #1;
        chk("mr_nogrant", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        chk("mr_valid", 32'(resp_valid), 32'd0);
        chk("mr_cnt", 32'(op_count), 32'd0);
        chk("mr_c", resp_c, 32'd0);
        chk("mr_id", 32'(resp_id), 32'd0);
        req_valid = 4'b1001;
        #1;
        chk("mr_ptr0", 32'(req_ready), 32'b0001);
        tick();
        resp_ready = 1'b1;
        req_valid  = '0;
        tick();

        // Counter wrap with a 4-bit counter
        do_reset();
        req_valid  = '1;
        resp_ready = 1'b1;
        for (int t = 1; t <= 17; t++) begin
            tick();
            if (t == 16) chk("wrap_15", 32'(op_count), 32'd15);
            if (t == 17) chk("wrap_0", 32'(op_count), 32'd0);
        end
        req_valid = '0;
        tick();
        chk("wrap_1", 32'(op_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
